// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and memory-op helpers
package pipeline_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RD,
        LSU_DONE
    } lsu_state_t;

    function automatic logic mem_is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    endfunction

    function automatic logic mem_is_byte(input mem_op_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_SB};
    endfunction

    function automatic logic mem_is_half(input mem_op_t op);
        return op inside {MEM_LH, MEM_LHU, MEM_SH};
    endfunction

    function automatic logic mem_is_word(input mem_op_t op);
        return op inside {MEM_LW, MEM_SW};
    endfunction

    function automatic logic mem_aligned(input mem_op_t op, input logic [1:0] addr);
        if (mem_is_half(op)) return !addr[0];
        if (mem_is_word(op)) return addr == 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [3:0] mem_be(input mem_op_t op, input logic [1:0] addr);
        if (mem_is_byte(op)) return 4'b0001 << addr;
        if (mem_is_half(op)) return addr[1] ? 4'b1100 : 4'b0011;
        if (mem_is_word(op)) return 4'b1111;
        return 4'b0000;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication / byte enables and load lane extraction
module lsu_align
    import pipeline_pkg::*;
(
    input  mem_op_t     st_op,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_wd,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  mem_op_t     ld_op,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = mem_be(st_op, st_addr);
        st_wdata = st_wd;
        if (mem_is_byte(st_op)) begin
            st_wdata = {4{st_wd[7:0]}};
        end else if (mem_is_half(st_op)) begin
            st_wdata = {2{st_wd[15:0]}};
        end

        case (ld_addr)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];

        case (ld_op)
            MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_LBU: ld_data = {24'd0, ld_byte};
            MEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_LHU: ld_data = {16'd0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/memory_lsu.sv
// rtl/memory_lsu.sv - memory-stage load/store unit: FSM, timeout counter, request registers
module memory_lsu
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [3:0]  m_mem_op,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_dmem_wd,
    output logic [31:0] m_dmem_rd,
    output logic        stall,
    output logic        misalign,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    mem_op_t     op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [9:0]  cnt_q, cnt_d;

    mem_op_t     op_in;
    logic        active, start, mis, expire;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    assign op_in  = mem_op_t'(m_mem_op);
    // Gated by reset so nothing combinational escapes while reset is held.
    assign active = reset && m_valid && (op_in != MEM_NONE) && (state_q == LSU_IDLE);
    assign start  = active && mem_aligned(op_in, m_alu_out[1:0]);
    assign mis    = active && !mem_aligned(op_in, m_alu_out[1:0]);
    assign expire = (cnt_q == TMO_LAST);

    lsu_align u_align (
        .st_op    (op_in),
        .st_addr  (m_alu_out[1:0]),
        .st_wd    (m_dmem_wd),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_op    (op_q),
        .ld_addr  (lane_q),
        .ld_rdata (dmem_rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        op_d      = op_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        stall     = 1'b0;
        dmem_req  = 1'b0;
        misalign  = mis;
        bus_error = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                stall = start;
                if (start) begin
                    addr_d  = {m_alu_out[31:2], 2'b00};
                    be_d    = st_be;
                    wdata_d = st_wdata;
                    we_d    = !mem_is_load(op_in);
                    op_d    = op_in;
                    lane_d  = m_alu_out[1:0];
                    cnt_d   = '0;
                    state_d = LSU_REQ;
                end else if (mis) begin
                    rd_d = '0;
                end
            end
            LSU_REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                cnt_d    = cnt_q + 10'd1;
                // A grant on the expiry cycle still completes the access.
                if (dmem_gnt) begin
                    state_d = mem_is_load(op_q) ? LSU_WAIT_RD : LSU_DONE;
                end else if (expire) begin
                    bus_error = 1'b1;
                    rd_d      = '0;
                    state_d   = LSU_DONE;
                end
            end
            LSU_WAIT_RD: begin
                stall = 1'b1;
                cnt_d = cnt_q + 10'd1;
                if (dmem_rvalid) begin
                    rd_d    = ld_data;
                    state_d = LSU_DONE;
                end else if (expire) begin
                    bus_error = 1'b1;
                    rd_d      = '0;
                    state_d   = LSU_DONE;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            op_q    <= MEM_NONE;
            lane_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    assign m_dmem_rd  = mis ? 32'd0 : rd_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_lsu.sv
// tb/tb_memory_lsu.sv - randomized self-checking bench for memory_lsu against a timeline model
module tb_memory_lsu;
    import pipeline_pkg::*;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_mem_op = 4'd0;
    logic [31:0] m_alu_out = 32'd0;
    logic [31:0] m_dmem_wd = 32'd0;
    logic [31:0] m_dmem_rd;
    logic        stall, misalign, bus_error, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;

    memory_lsu #(.TIMEOUT(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_mem_op    (m_mem_op),
        .m_alu_out   (m_alu_out),
        .m_dmem_wd   (m_dmem_wd),
        .m_dmem_rd   (m_dmem_rd),
        .stall       (stall),
        .misalign    (misalign),
        .bus_error   (bus_error),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic        req;
        logic        mis;
        logic        berr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_cnt = 0, req_cnt = 0, berr_cnt = 0, mis_cnt = 0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        req_we = 1'b0;
    logic [31:0] model_rd = 32'd0;
    logic [31:0] x_addr = 32'd0, x_wdata = 32'd0;
    logic [3:0]  x_be = 4'd0;
    logic        x_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [3:0] op);
        return op >= MEM_LB && op <= MEM_LW;
    endfunction

    function automatic bit model_aligned(input logic [3:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        return sz == 0 || (int'(addr[1:0]) % sz) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] addr);
        int sz   = op_size(op);
        int a    = int'(addr[1:0]);
        int lane = a - a % sz;
        return 4'(((1 << sz) - 1) << lane);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] wd);
        case (op_size(op))
            1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int          sz   = op_size(op);
        int          a    = int'(addr[1:0]);
        int          lane = a - a % sz;
        int          bits = 8 * sz;
        logic [31:0] v    = rdata >> (8 * lane);
        logic [31:0] mask;
        if (sz < 4) begin
            mask = (32'd1 << bits) - 32'd1;
            v    = v & mask;
            if ((op == MEM_LB || op == MEM_LH) && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic push(input logic st, input logic rq, input logic ms, input logic be_err);
        exp_t e;
        e.stall = st;
        e.req   = rq;
        e.mis   = ms;
        e.berr  = be_err;
        e.addr  = x_addr;
        e.wdata = x_wdata;
        e.be    = x_be;
        e.we    = x_we;
        e.rd    = model_rd;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin : cmp
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk1("stall", stall, e.stall);
            chk1("dmem_req", dmem_req, e.req);
            chk1("misalign", misalign, e.mis);
            chk1("bus_error", bus_error, e.berr);
            chk("m_dmem_rd", m_dmem_rd, e.rd);
            if (e.req) begin
                chk("dmem_addr", dmem_addr, e.addr);
                chk("dmem_be", 32'(dmem_be), 32'(e.be));
                chk("dmem_wdata", dmem_wdata, e.wdata);
                chk1("dmem_we", dmem_we, e.we);
            end
        end
        if (stall) stall_cnt++;
        if (bus_error) berr_cnt++;
        if (misalign) mis_cnt++;
        if (dmem_req) begin
            req_cnt++;
            req_addr  = dmem_addr;
            req_be    = dmem_be;
            req_wdata = dmem_wdata;
            req_we    = dmem_we;
        end
    end

    // g: REQ cycles without grant before the granting one; k: cycles from gnt to rvalid (>=1).
    task automatic run_txn(input bit vld, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int g, input int k,
                           input logic [31:0] rdata);
        int c, gc;
        bit granted, fin, berr, rv, ld;
        stall_cnt = 0; req_cnt = 0; berr_cnt = 0; mis_cnt = 0;
        m_valid     = vld;
        m_mem_op    = op;
        m_alu_out   = addr;
        m_dmem_wd   = wd;
        dmem_gnt    = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        ld          = op_load(op);
        if (!vld || op_size(op) == 0) begin
            push(1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end else if (!model_aligned(op, addr)) begin
            model_rd = 32'd0;
            push(1'b0, 1'b0, 1'b1, 1'b0);
            step();
        end else begin
            x_addr  = addr & ~32'd3;
            x_be    = model_be(op, addr);
            x_wdata = model_wdata(op, wd);
            x_we    = !ld;
            push(1'b1, 1'b0, 1'b0, 1'b0);
            step();
            granted = 1'b0; fin = 1'b0; c = 0; gc = 0;
            while (!fin) begin
                c++;
                berr = 1'b0;
                if (!granted) begin
                    dmem_gnt    = (c == g + 1);
                    dmem_rvalid = 1'($urandom_range(0, 1));
                    dmem_rdata  = $urandom;
                    if (c == g + 1) begin
                        granted = 1'b1;
                        gc      = c;
                        fin     = !ld;
                    end else if (c == TMO) begin
                        berr = 1'b1;
                        fin  = 1'b1;
                    end
                    push(1'b1, 1'b1, 1'b0, berr);
                end else begin
                    rv          = (c == gc + k);
                    dmem_gnt    = 1'b0;
                    dmem_rvalid = rv;
                    dmem_rdata  = rv ? rdata : $urandom;
                    if (rv) fin = 1'b1;
                    else if (c == TMO) begin
                        berr = 1'b1;
                        fin  = 1'b1;
                    end
                    push(1'b1, 1'b0, 1'b0, berr);
                    if (rv) model_rd = model_load(op, addr, rdata);
                end
                if (berr) model_rd = 32'd0;
                step();
            end
            dmem_gnt    = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = $urandom;
            push(1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        m_valid     = 1'b0;
        m_mem_op    = 4'd0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rd", m_dmem_rd, 32'd0);
        chk1("rst_misalign", misalign, 1'b0);
        chk1("rst_bus_error", bus_error, 1'b0);
        reset = 1'b1;
        step();

        run_txn(1, MEM_LW, 32'h100, 32'd0, 0, 2, 32'hDEADBEEF);
        chk("lw_stall_cycles", stall_cnt, 32'd4);
        chk("lw_addr", req_addr, 32'h100);
        chk("lw_be", 32'(req_be), 32'hF);
        chk("lw_rd", m_dmem_rd, 32'hDEADBEEF);

        run_txn(1, MEM_LB, 32'h103, 32'd0, 0, 1, 32'h80112233);
        chk("lb_be", 32'(req_be), 32'h8);
        chk("lb_rd", m_dmem_rd, 32'hFFFFFF80);
        run_txn(1, MEM_LBU, 32'h103, 32'd0, 0, 1, 32'h80112233);
        chk("lbu_rd", m_dmem_rd, 32'h00000080);

        run_txn(1, MEM_LW, 32'h40, 32'd0, 100, 1, 32'h12345678);
        chk("tmo_berr_count", berr_cnt, 32'd1);
        chk("tmo_req_cycles", req_cnt, 32'd8);
        chk("tmo_rd", m_dmem_rd, 32'd0);
        run_txn(1, MEM_SW, 32'h44, 32'h55AA55AA, 7, 1, 32'd0);
        chk("gnt_at_expiry_berr", berr_cnt, 32'd0);
        chk("gnt_at_expiry_req", req_cnt, 32'd8);

        run_txn(1, MEM_SH, 32'h22, 32'h1234ABCD, 3, 1, 32'd0);
        chk("sh_addr", req_addr, 32'h20);
        chk("sh_be", 32'(req_be), 32'hC);
        chk("sh_wdata", req_wdata, 32'hABCDABCD);
        chk1("sh_we", req_we, 1'b1);
        chk("sh_req_cycles", req_cnt, 32'd4);
        chk("sh_stall_cycles", stall_cnt, 32'd5);

        run_txn(1, MEM_LW, 32'h104, 32'd0, 0, 1, 32'h11111111);
        chk("lw2_rd", m_dmem_rd, 32'h11111111);
        run_txn(1, MEM_LW, 32'h102, 32'd0, 0, 1, 32'h22222222);
        chk("mis_lw_pulse", mis_cnt, 32'd1);
        chk("mis_lw_req", req_cnt, 32'd0);
        chk("mis_lw_stall", stall_cnt, 32'd0);
        chk("mis_lw_rd", m_dmem_rd, 32'd0);
        run_txn(1, MEM_SH, 32'h21, 32'hFFFF0000, 0, 1, 32'd0);
        chk("mis_sh_pulse", mis_cnt, 32'd1);
        chk("mis_sh_req", req_cnt, 32'd0);
        chk("mis_sh_stall", stall_cnt, 32'd0);

        // Reset while waiting for read data, then a stray rvalid after release.
        m_valid   = 1'b1;
        m_mem_op  = MEM_LW;
        m_alu_out = 32'h200;
        step();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk1("wait_rd_stall", stall, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("async_rst_stall", stall, 1'b0);
        chk1("async_rst_req", dmem_req, 1'b0);
        chk("async_rst_addr", dmem_addr, 32'd0);
        chk("async_rst_be", 32'(dmem_be), 32'd0);
        chk1("async_rst_we", dmem_we, 1'b0);
        chk("async_rst_rd", m_dmem_rd, 32'd0);
        m_valid     = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        step();
        reset = 1'b1;
        step();
        dmem_rvalid = 1'b0;
        chk1("late_rvalid_stall", stall, 1'b0);
        chk("late_rvalid_rd", m_dmem_rd, 32'd0);
        model_rd = 32'd0;
        run_txn(1, MEM_LW, 32'h300, 32'd0, 1, 3, 32'h0BADF00D);
        chk("post_rst_lw_rd", m_dmem_rd, 32'h0BADF00D);
        chk("post_rst_lw_stall", stall_cnt, 32'd6);

        for (int i = 0; i < 300; i++) begin
            bit          vld;
            logic [3:0]  op;
            int          g, k;
            vld = ($urandom_range(0, 7) != 0);
            op  = 4'($urandom_range(0, 8));
            g   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 2));
            k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 3));
            run_txn(vld, op, $urandom, $urandom, g, k, $urandom);
        end

        step();
        step();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_lsu.md
Name: memory_lsu

Overview:
Load/store unit for the memory stage of the 5-stage MIPS pipeline. It sits between the memory pipeline register and writeback_reg.
- Takes the memory-stage address, store data and memory op.
- Drives a req/gnt/rvalid data-memory port with byte enables.
- Stalls the pipeline while an access is outstanding.
- Produces the aligned, sign- or zero-extended load data m_dmem_rd, which writeback_reg captures.

Parameters:
TIMEOUT, 255, maximum cycles spent in REQ+WAIT_RD before a bus error is declared (1..1023)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
m_valid  input  1  memory-stage slot holds a real instruction
m_mem_op  input  4  mem_op_t: MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
m_alu_out  input  32  effective byte address
m_dmem_wd  input  32  store data, right-justified
m_dmem_rd  output  32  aligned/extended load result to writeback_reg
stall  output  1  freeze fetch..memory regs; bubble into writeback
misalign  output  1  one-cycle pulse, misaligned access dropped
bus_error  output  1  one-cycle pulse, access timed out
dmem_req  output  1  request valid, held until gnt
dmem_we  output  1  1 = write
dmem_addr  output  32  word address, bits[1:0] = 0
dmem_be  output  4  byte enables, little-endian
dmem_wdata  output  32  lane-replicated store data
dmem_gnt  input  1  request accepted this cycle
dmem_rvalid  input  1  read data valid, strictly after gnt
dmem_rdata  input  32  read data

Behaviour:
- Reset values: state IDLE; all outputs 0; internal registers 0. Reset takes effect immediately on any cycle. After reset, dmem_req drops at once and a late rvalid/gnt is ignored.
- start = m_valid && op != MEM_NONE && aligned in IDLE.
- Alignment rules:
  - H ops require addr[0]=0.
  - W ops require addr[1:0]=0.
  - B ops are always aligned.
- Misaligned access, in IDLE:
  - misalign pulses for 1 cycle.
  - No request is issued, stall stays 0, m_dmem_rd is forced to 0.
  - Stores write nothing.
- Stall: stall = (IDLE && start) || REQ || WAIT_RD. stall is 0 in DONE.
- IDLE, on start:
  - Register dmem_addr = addr & ~3, dmem_be, dmem_wdata, dmem_we, and the op.
  - Clear the timeout counter.
  - Next state REQ.
- REQ: dmem_req=1, address/be/data held stable. When gnt is seen:
  - store -> DONE
  - load -> WAIT_RD
- WAIT_RD: dmem_req=0. On rvalid, capture the extracted/extended dmem_rdata into m_dmem_rd, then go to DONE.
- Timeout: the counter increments in REQ and WAIT_RD. When it reaches TIMEOUT with no gnt/rvalid:
  - bus_error pulses 1 cycle.
  - m_dmem_rd is set to 0 and dmem_req drops.
  - Next state DONE.
- DONE:
  - stall=0 and m_dmem_rd is held, so writeback captures it at this edge.
  - Next state IDLE unconditionally; the same instruction never re-triggers.
- m_dmem_rd holds its last value outside DONE. It is don't-care for non-load ops.
- Byte enables by op:
  - B: be = 1 << addr[1:0], wdata = {4{wd[7:0]}}.
  - H: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wd[15:0]}}.
  - W: be = 4'b1111, wdata = wd.
  - Loads drive the same be.
- Load extraction: select the lane by addr[1:0] (H: addr[1]).
  - LB/LH sign-extend to 32.
  - LBU/LHU zero-extend.
- Latency, in stall cycles:
  - Store with gnt in the first REQ cycle: 2.
  - Load with gnt immediate and rvalid k cycles after gnt: 2+k.
- Simultaneous gnt and timeout expiry: gnt wins, no bus_error.
- rvalid seen outside WAIT_RD: ignored.

Decomposition:
- pipeline_pkg gains:
  - mem_op_t (4-bit enum)
  - lsu_state_t (IDLE, REQ, WAIT_RD, DONE)
  - functions mem_be(op, addr) and mem_is_load(op)
- Sub-module lsu_align (combinational):
  - store lane replication and byte-enable generation
  - load lane select and sign/zero extension
- memory_lsu keeps the FSM, timeout counter and registers.

Test Plan:
- LW addr 0x100, gnt on first REQ cycle, rvalid 2 cycles later with 0xDEADBEEF -> dmem_addr 0x100, be 1111, stall high 4 cycles, m_dmem_rd 0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80112233 -> be 1000, m_dmem_rd 0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x22, wd 0x1234ABCD, gnt after 3 cycles -> dmem_addr 0x20, be 1100, wdata 0xABCDABCD, we=1, req held 4 cycles, stall 5 cycles.
- LW addr 0x102 and SH addr 0x21 -> misalign pulse each, dmem_req never asserted, stall 0, m_dmem_rd 0.
- TIMEOUT=8, gnt held low -> bus_error pulse after 8 REQ cycles, req drops, DONE then IDLE, m_dmem_rd 0. Also gnt on the expiry cycle -> no bus_error.
- Reset asserted in WAIT_RD with a late rvalid -> outputs 0 immediately, state IDLE, rvalid ignored, next LW completes normally.
